// File: rtl/dpic_mem_master.sv
// rtl/dpic_mem_master.sv - single-outstanding load/store initiator for the DPI-C memory port
module dpic_mem_master #(
    parameter int LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic [63:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        mem_we_en,
    output logic [63:0] mem_we_addr,
    output logic [63:0] mem_we_data,
    output logic [7:0]  mem_we_mask
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    // Width never drops to zero so LATENCY = 0 still elaborates.
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          wen_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [63:0]   rdata_q;
    logic          err_q;
    logic          accept;
    logic          misaligned;

    function automatic logic [63:0] size_bits(input logic [1:0] size);
        case (size)
            2'd0:    size_bits = 64'h0000_0000_0000_00FF;
            2'd1:    size_bits = 64'h0000_0000_0000_FFFF;
            2'd2:    size_bits = 64'h0000_0000_FFFF_FFFF;
            default: size_bits = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            2'd0:    extend = {{56{sgn & d[7]}},  d[7:0]};
            2'd1:    extend = {{48{sgn & d[15]}}, d[15:0]};
            2'd2:    extend = {{32{sgn & d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    assign accept     = req_valid && (state == IDLE);
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = misaligned ? RESP : ACCESS;
            ACCESS:  state_next = (LATENCY > 0) ? WAIT : RESP;
            WAIT:    if (cnt == '0) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are loaded on acceptance so they are high exactly during ACCESS.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_we_en   <= 1'b0;
            mem_we_addr <= '0;
            mem_we_data <= '0;
            mem_we_mask <= '0;
            cnt         <= '0;
            wen_q       <= 1'b0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_we_en   <= 1'b0;
            mem_we_addr <= '0;
            mem_we_data <= '0;
            mem_we_mask <= '0;
            if (accept && !misaligned) begin
                if (req_wen) begin
                    mem_we_en   <= 1'b1;
                    mem_we_addr <= req_addr;
                    mem_we_data <= req_wdata & size_bits(req_size);
                    mem_we_mask <= size_mask(req_size);
                end else begin
                    mem_rd_en   <= 1'b1;
                    mem_rd_addr <= req_addr;
                end
            end
            if (accept) begin
                wen_q    <= req_wen;
                size_q   <= req_size;
                signed_q <= req_signed;
                rdata_q  <= '0;
                err_q    <= misaligned;
            end
            if (state == ACCESS && !wen_q) begin
                rdata_q <= extend(mem_rd_data, size_q, signed_q);
            end
            if (LATENCY > 0 && state == ACCESS) begin
                cnt <= CW'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dpic_mem_master.sv
// tb/tb_dpic_mem_master.sv - directed bench for dpic_mem_master with a byte-array memory model
module tb_dpic_mem_master;
    localparam int LAT = 3;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd_en;
    logic [63:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        mem_we_en;
    logic [63:0] mem_we_addr;
    logic [63:0] mem_we_data;
    logic [7:0]  mem_we_mask;

    dpic_mem_master #(.LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr),
        .mem_we_data(mem_we_data), .mem_we_mask(mem_we_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // 64-byte window; every test address lives in 0x80000000..0x8000000F.
    logic [7:0] mem [0:63];
    int rd_cnt = 0;
    int we_cnt = 0;

    always_comb begin
        mem_rd_data = '0;
        for (int i = 0; i < 8; i++)
            mem_rd_data[8*i +: 8] = mem[6'(mem_rd_addr[5:0] + 6'(i))];
    end

    always @(posedge clock) begin
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_we_en) begin
            we_cnt <= we_cnt + 1;
            for (int i = 0; i < 8; i++)
                if (mem_we_mask[i]) mem[6'(mem_we_addr[5:0] + 6'(i))] <= mem_we_data[8*i +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    int          o_lat;
    logic [63:0] o_rdata;
    logic        o_err;
    int          o_nrd;
    int          o_nwe;
    logic        o_we1;
    logic        o_rd1;
    logic [63:0] o_wd1;
    logic [63:0] o_wa1;
    logic [7:0]  o_wm1;
    logic        o_we2;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request with resp_ready held high; snapshots cycle 1 and 2 strobes.
    task automatic op(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [63:0] wdata);
        int rd0;
        int we0;
        rd0 = rd_cnt;
        we0 = we_cnt;
        req_wen    = wen;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        o_lat = 1;
        o_we1 = mem_we_en;
        o_rd1 = mem_rd_en;
        o_wd1 = mem_we_data;
        o_wa1 = mem_we_addr;
        o_wm1 = mem_we_mask;
        o_we2 = 1'b0;
        while (!resp_valid && o_lat < 40) begin
            tick();
            o_lat++;
            if (o_lat == 2) o_we2 = mem_we_en;
        end
        o_rdata = resp_rdata;
        o_err   = resp_err;
        tick();
        o_nrd = rd_cnt - rd0;
        o_nwe = we_cnt - we0;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_signed = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_strobes", {62'd0, mem_rd_en, mem_we_en}, 64'd0);
        chk("rst_mask", 64'(mem_we_mask), 64'd0);
        reset = 1'b1;
        tick();

        op(1'b1, 64'h8000_0000, 2'd3, 1'b0, 64'h1122_3344_5566_7788);
        chk("st8_we1", 64'(o_we1), 64'd1);
        chk("st8_rd1", 64'(o_rd1), 64'd0);
        chk("st8_mask", 64'(o_wm1), 64'hFF);
        chk("st8_data", o_wd1, 64'h1122_3344_5566_7788);
        chk("st8_addr", o_wa1, 64'h8000_0000);
        chk("st8_lat", 64'(o_lat), 64'd5);
        chk("st8_pulses", {32'(o_nrd), 32'(o_nwe)}, {32'd0, 32'd1});
        chk("st8_resp", {o_rdata, 63'd0, o_err}, 127'd0);

        op(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'h0);
        chk("ld8_rdata", o_rdata, 64'h1122_3344_5566_7788);
        chk("ld8_err", 64'(o_err), 64'd0);
        chk("ld8_pulses", {32'(o_nrd), 32'(o_nwe)}, {32'd1, 32'd0});

        op(1'b1, 64'h8000_0007, 2'd0, 1'b0, 64'hAAAA_AAAA_AAAA_AA80);
        chk("st1_mask", 64'(o_wm1), 64'h01);
        chk("st1_data", o_wd1, 64'h80);
        op(1'b0, 64'h8000_0007, 2'd0, 1'b1, 64'h0);
        chk("ld1_signed", o_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        op(1'b0, 64'h8000_0007, 2'd0, 1'b0, 64'h0);
        chk("ld1_unsigned", o_rdata, 64'h0000_0000_0000_0080);

        op(1'b1, 64'h8000_0004, 2'd2, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);
        chk("st4_data", o_wd1, 64'h0000_0000_DEAD_BEEF);
        chk("st4_mask", 64'(o_wm1), 64'h0F);
        chk("st4_one_cycle", {62'd0, o_we1, o_we2}, 64'b10);
        op(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'h0);
        chk("ld8_after_st4", o_rdata, 64'hDEAD_BEEF_5566_7788);
        op(1'b0, 64'h8000_0006, 2'd1, 1'b1, 64'h0);
        chk("ld2_signed", o_rdata, 64'hFFFF_FFFF_FFFF_DEAD);
        op(1'b0, 64'h8000_0004, 2'd2, 1'b0, 64'h0);
        chk("ld4_unsigned", o_rdata, 64'h0000_0000_DEAD_BEEF);

        op(1'b1, 64'h8000_0003, 2'd1, 1'b0, 64'h1234);
        chk("mis_lat", 64'(o_lat), 64'd1);
        chk("mis_err", 64'(o_err), 64'd1);
        chk("mis_rdata", o_rdata, 64'd0);
        chk("mis_pulses", {32'(o_nrd), 32'(o_nwe)}, {32'd0, 32'd0});
        chk("mis_strobe1", {62'd0, o_rd1, o_we1}, 64'd0);

        // Response back-pressure with a second request waiting.
        req_wen = 1'b0; req_addr = 64'h8000_0000; req_size = 2'd3; req_signed = 1'b0;
        req_valid = 1'b1; resp_ready = 1'b0;
        tick();
        req_addr = 64'h8000_0001; req_size = 2'd0;
        o_lat = 1;
        while (!resp_valid && o_lat < 40) begin
            chk("bp_ready_low_pre", 64'(req_ready), 64'd0);
            tick();
            o_lat++;
        end
        chk("bp_lat", 64'(o_lat), 64'd5);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_rdata", resp_rdata, 64'hDEAD_BEEF_5566_7788);
            chk("bp_err", 64'(resp_err), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            if (k < 3) tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_next_ready", 64'(req_ready), 64'd1);
        chk("bp_next_valid", 64'(resp_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        chk("bp2_rd_en", 64'(mem_rd_en), 64'd1);
        chk("bp2_rd_addr", mem_rd_addr, 64'h8000_0001);
        o_lat = 1;
        while (!resp_valid && o_lat < 40) begin
            tick();
            o_lat++;
        end
        chk("bp2_lat", 64'(o_lat), 64'd5);
        chk("bp2_rdata", resp_rdata, 64'h77);
        tick();

        // Reset while in WAIT abandons the access.
        req_wen = 1'b0; req_addr = 64'h8000_0000; req_size = 2'd3;
        req_valid = 1'b1; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_resp", {resp_rdata, 62'd0, resp_valid, resp_err}, 128'd0);
        chk("mid_rst_mem", {mem_rd_addr, 62'd0, mem_rd_en, mem_we_en}, 128'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("mid_rst_no_resp", 64'(resp_valid), 64'd0);
            tick();
        end
        op(1'b0, 64'h8000_0000, 2'd0, 1'b0, 64'h0);
        chk("post_rst_lat", 64'(o_lat), 64'd5);
        chk("post_rst_rdata", o_rdata, 64'h88);
        chk("post_rst_err", 64'(o_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
